aes_key_expand: RTL and testbench

//  Iterative AES-128 key schedule; upstream feeder of the aes cipher core.

---
 rtl/aes_key_expand_pkg.sv | 40 ++++
 rtl/aes_key_expand_if.sv | 33 +++
 rtl/aes_key_expand_sbox.sv | 31 +++
 rtl/aes_key_expand.sv | 166 ++++++++++++++++
 tb/tb_aes_key_expand.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_key_expand_pkg.sv
// aes_key_expand_pkg
//   Shared types, constants and helpers for the iterative AES-128 key schedule
//   and the cipher core that consumes its round keys.
//   Byte i of a block is bits [8i+:8]; word j is bits [32j+:32], and byte 0 of
//   a word is its least significant byte.
//   Optional feature macro used by the block: AES_KEY_STORE_EN.
package aes_key_expand_pkg;

  typedef logic [31:0]  word_t;
  typedef logic [127:0] block_t;

  // AES-128 round count; the key schedule produces NR+1 round keys.
  localparam int NR = 10;

  // FSM state encoding.
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // Round constants, indexed by the round that is being generated.
  localparam logic [7:0] RCON [1:10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                         8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

  // RotWord: bytes [a0,a1,a2,a3] -> [a1,a2,a3,a0]; with byte 0 at the LSB this
  // is a right rotation of the word value by one byte.
  function automatic word_t rot_word(input word_t w);
    return {w[7:0], w[31:8]};
  endfunction

  // Round-constant lookup; indices outside 1..10 return zero.
  function automatic logic [7:0] rcon(input logic [3:0] k);
    logic [7:0] r;
    if ((k >= 4'd1) && (k <= 4'd10)) begin
      r = RCON[k];
    end else begin
      r = 8'h00;
    end
    return r;
  endfunction

endpackage

// File: rtl/aes_key_expand_if.sv
// aes_key_expand_if
//   Bus between the key-schedule block and its user.
//   master : drives start/key_in (and rd_idx), receives the round-key stream.
//   slave  : the key-schedule block itself.
//   Signals: start, key_in[127:0], busy, rk_valid, rk_idx[3:0], rk_out[127:0],
//   done; with AES_KEY_STORE_EN also rd_idx[3:0], rd_key[127:0], key_ready.
interface aes_key_expand_if;
  import aes_key_expand_pkg::*;

  logic        start;
  block_t      key_in;
  logic        busy;
  logic        rk_valid;
  logic [3:0]  rk_idx;
  block_t      rk_out;
  logic        done;
`ifdef AES_KEY_STORE_EN
  logic [3:0]  rd_idx;
  block_t      rd_key;
  logic        key_ready;

  modport master (output start, key_in, rd_idx,
                  input  busy, rk_valid, rk_idx, rk_out, done, rd_key, key_ready);
  modport slave  (input  start, key_in, rd_idx,
                  output busy, rk_valid, rk_idx, rk_out, done, rd_key, key_ready);
`else
  modport master (output start, key_in,
                  input  busy, rk_valid, rk_idx, rk_out, done);
  modport slave  (input  start, key_in,
                  output busy, rk_valid, rk_idx, rk_out, done);
`endif

endinterface

// File: rtl/aes_key_expand_sbox.sv
// aes_sbox
//   Combinational 8-bit AES S-box (forward direction). Four instances form
//   SubWord in the key schedule; the cipher core instantiates the same module.
//   Ports: x (in, 8) input byte; y (out, 8) substituted byte.
module aes_sbox (
  input  logic [7:0] x,
  output logic [7:0] y
);

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign y = SBOX[x];

endmodule

// File: rtl/aes_key_expand.sv
// aes_key_expand
//   Iterative AES-128 key schedule. An accepted start loads the cipher key and
//   the block then emits round keys rk0..rk10, one per clock, as a registered
//   stream. done pulses together with rk10; a start presented while rk10 is on
//   the outputs is accepted so that back-to-back expansions have no gap.
//   Ports:
//     clk  (in)  rising-edge clock
//     rst  (in)  asynchronous, active-high reset
//     bus  (aes_key_expand_if.slave) start, key_in, busy, rk_valid, rk_idx,
//          rk_out, done; with AES_KEY_STORE_EN also rd_idx, rd_key, key_ready.
//   Build option AES_KEY_STORE_EN: keeps rk0..rk10 in a readable register file.
//   Parameter NR: must be 10 (AES-128); any other value stops elaboration.
module aes_key_expand #(
  parameter int NR = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  aes_key_expand_if.slave       bus
);
  import aes_key_expand_pkg::*;

  if (NR != aes_key_expand_pkg::NR) begin : g_nr_check
    $error("aes_key_expand: only NR=10 (AES-128) is supported");
  end

  logic [0:0] state_r;
  logic [3:0] cnt_r;
  block_t     key_r;
  logic       valid_r;
  logic       busy_r;
  logic       done_r;

  logic       accept_s;
  logic       step_s;
  logic       load_s;
  logic [3:0] cnt_nxt_s;
  block_t     key_nxt_s;
  block_t     key_step_s;
  word_t      rot_s;
  word_t      sub_s;
  word_t      t_s;
  word_t      w0_s;
  word_t      w1_s;
  word_t      w2_s;
  word_t      w3_s;

  // SubWord of the rotated last word of the current round key.
  assign rot_s = rot_word(key_r[127:96]);

  for (genvar i = 0; i < 4; i++) begin : g_subword
    aes_sbox u_sbox (
      .x (rot_s[8*i +: 8]),
      .y (sub_s[8*i +: 8])
    );
  end

  // Next round key from the current one; cnt_r holds k, so Rcon[k+1] is used.
  always_comb begin
    t_s        = sub_s ^ {24'h000000, rcon(cnt_r + 4'd1)};
    w0_s       = key_r[31:0]   ^ t_s;
    w1_s       = key_r[63:32]  ^ w0_s;
    w2_s       = key_r[95:64]  ^ w1_s;
    w3_s       = key_r[127:96] ^ w2_s;
    key_step_s = {w3_s, w2_s, w1_s, w0_s};
  end

  // Start acceptance and next-value selection for counter and key register.
  always_comb begin
    accept_s  = bus.start && ((state_r == ST_IDLE) || (cnt_r == 4'd10));
    step_s    = (state_r == ST_RUN) && (cnt_r < 4'd10);
    load_s    = accept_s || step_s;
    cnt_nxt_s = cnt_r;
    key_nxt_s = key_r;
    if (accept_s) begin
      cnt_nxt_s = 4'd0;
      key_nxt_s = bus.key_in;
    end else if (step_s) begin
      cnt_nxt_s = cnt_r + 4'd1;
      key_nxt_s = key_step_s;
    end else begin
      cnt_nxt_s = cnt_r;
      key_nxt_s = key_r;
    end
  end

  // FSM, round counter, key register and registered stream flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      key_r   <= '0;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else if (accept_s) begin
      state_r <= ST_RUN;
      cnt_r   <= cnt_nxt_s;
      key_r   <= key_nxt_s;
      valid_r <= 1'b1;
      busy_r  <= 1'b1;
      done_r  <= 1'b0;
    end else if (step_s) begin
      cnt_r   <= cnt_nxt_s;
      key_r   <= key_nxt_s;
      valid_r <= 1'b1;
      busy_r  <= 1'b1;
      done_r  <= (cnt_r == 4'd9);
    end else begin
      // rk10 has been shown (or nothing is running): drop to IDLE and keep
      // rk_out/rk_idx at their last values.
      state_r <= ST_IDLE;
      valid_r <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end
  end

  assign bus.busy     = busy_r;
  assign bus.rk_valid = valid_r;
  assign bus.rk_idx   = cnt_r;
  assign bus.rk_out   = key_r;
  assign bus.done     = done_r;

`ifdef AES_KEY_STORE_EN
  block_t store_r [0:10];
  logic   key_ready_r;

  // Round-key store: each key is written on the edge that puts it on rk_out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i <= 10; i++) begin
        store_r[i] <= '0;
      end
    end else if (load_s) begin
      store_r[cnt_nxt_s] <= key_nxt_s;
    end else begin
      store_r <= store_r;
    end
  end

  // key_ready rises with done and falls on the next accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_ready_r <= 1'b0;
    end else if (accept_s) begin
      key_ready_r <= 1'b0;
    end else if (step_s && (cnt_r == 4'd9)) begin
      key_ready_r <= 1'b1;
    end else begin
      key_ready_r <= key_ready_r;
    end
  end

  // Asynchronous read port; indices past rk10 read as zero.
  always_comb begin
    if (bus.rd_idx <= 4'd10) begin
      bus.rd_key = store_r[bus.rd_idx];
    end else begin
      bus.rd_key = '0;
    end
  end

  assign bus.key_ready = key_ready_r;
`endif

endmodule

// File: tb/tb_aes_key_expand.sv
// tb_aes_key_expand
//   Scoreboard bench for aes_key_expand. A predictor applies the start
//   acceptance rules on each rising edge and queues the eleven expected round
//   keys, computed by a word-array FIPS-197 key expansion whose S-box is built
//   from GF(2^8) inversion plus the affine map. A monitor pops and compares on
//   every falling edge. Covers AES_KEY_STORE_EN when that macro is defined.
module tb_aes_key_expand;
  import aes_key_expand_pkg::*;

  localparam logic [127:0] K1     = 128'h3c4fcf098815f7aba6d2ae2816157e2b;
  localparam logic [127:0] K1_RK1 = 128'h05766c2a3939a323b12c548817fefaa0;
  localparam logic [127:0] K1_R10 = 128'ha60c63b6c80c3fe18925eec9a8f914d0;
  localparam logic [127:0] Z_RK1  = 128'h63636362636363626363636263636362;
  localparam logic [127:0] Z_R10  = 128'h8e188f6fcf51e92311e2923ecb5befb4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aes_key_expand_if bus ();

  aes_key_expand #(.NR(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [3:0]   idx;
    logic [127:0] key;
    logic         last;
  } exp_t;

  int           total = 0;
  int           bad   = 0;
  exp_t         q[$];
  int           phase = -1;
  logic [7:0]   sbox_tab [256];
  exp_t         mon_e;
  logic [3:0]   hold_idx = 4'd0;
  logic [127:0] hold_key = 128'd0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p = 8'h00; aa = a; bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = xtime(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // Reference round key k of the FIPS-197 expansion of key.
  function automatic logic [127:0] ref_rk(input logic [127:0] key, input int k);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[32*i +: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        // RotWord then SubWord: new byte0=a1, byte1=a2, byte2=a3, byte3=a0.
        t = {sbox_tab[t[7:0]], sbox_tab[t[31:24]], sbox_tab[t[23:16]], sbox_tab[t[15:8]]};
        t[7:0] = t[7:0] ^ rc;
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*k+3], w[4*k+2], w[4*k+1], w[4*k]};
  endfunction

  // S-box from multiplicative inverse and affine transform.
  initial begin
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv;
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sbox_tab[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  end

  // Predictor: acceptance rules and expected stream per accepted start.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      phase = -1;
    end else if (bus.start && (phase < 0 || phase == 10)) begin
      for (int k = 0; k <= 10; k++) begin
        exp_t e;
        e.idx  = 4'(k);
        e.key  = ref_rk(bus.key_in, k);
        e.last = (k == 10);
        q.push_back(e);
      end
      phase = 0;
    end else if (phase >= 0) begin
      phase++;
      if (phase > 10) phase = -1;
    end
  end

  // Monitor: one expected entry per cycle while a sequence is pending.
  always @(negedge clk) begin
    if (rst) begin
      hold_idx = 4'd0;
      hold_key = 128'd0;
    end else if (q.size() > 0) begin
      mon_e = q.pop_front();
      check("rk_valid", 128'(bus.rk_valid), 128'd1);
      check("rk_idx",   128'(bus.rk_idx),   128'(mon_e.idx));
      check("rk_out",   bus.rk_out,         mon_e.key);
      check("done",     128'(bus.done),     128'(mon_e.last));
      check("busy",     128'(bus.busy),     128'd1);
      hold_idx = mon_e.idx;
      hold_key = mon_e.key;
    end else begin
      check("idle rk_valid", 128'(bus.rk_valid), 128'd0);
      check("idle done",     128'(bus.done),     128'd0);
      check("idle busy",     128'(bus.busy),     128'd0);
      check("idle rk_idx",   128'(bus.rk_idx),   128'(hold_idx));
      check("idle rk_out",   bus.rk_out,         hold_key);
    end
  end

  task automatic wait_rk(input int k);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 30 && !ok; n++) begin
      @(negedge clk);
      if (bus.rk_valid && bus.rk_idx == 4'(k)) ok = 1'b1;
    end
    check($sformatf("reach rk_idx %0d", k), 128'(ok), 128'd1);
  endtask

  task automatic pulse_start(input logic [127:0] key);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.key_in = key;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.key_in = {$urandom, $urandom, $urandom, $urandom};
  endtask

  initial begin
    logic [127:0] k3;
    bus.start  = 1'b0;
    bus.key_in = 128'd0;
`ifdef AES_KEY_STORE_EN
    bus.rd_idx = 4'd0;
`endif
    // Reset state.
    repeat (2) @(negedge clk);
    check("reset busy",     128'(bus.busy),     128'd0);
    check("reset rk_valid", 128'(bus.rk_valid), 128'd0);
    check("reset done",     128'(bus.done),     128'd0);
    check("reset rk_idx",   128'(bus.rk_idx),   128'd0);
    check("reset rk_out",   bus.rk_out,         128'd0);
`ifdef AES_KEY_STORE_EN
    check("reset key_ready", 128'(bus.key_ready), 128'd0);
`endif
    #2 rst = 1'b0;

    // FIPS-197 key.
    pulse_start(K1);
    check("fips rk0", bus.rk_out, K1);
    wait_rk(1);
    check("fips rk1", bus.rk_out, K1_RK1);
    wait_rk(10);
    check("fips rk10", bus.rk_out, K1_R10);
    check("fips done", 128'(bus.done), 128'd1);
    repeat (2) @(negedge clk);

`ifdef AES_KEY_STORE_EN
    check("key_ready after done", 128'(bus.key_ready), 128'd1);
    for (int i = 0; i < 16; i++) begin
      bus.rd_idx = 4'(i);
      #1;
      check($sformatf("rd_key %0d", i), bus.rd_key, (i <= 10) ? ref_rk(K1, i) : 128'd0);
    end
    check("key_ready still set", 128'(bus.key_ready), 128'd1);
`endif

    // Starts while busy are ignored.
    pulse_start(K1);
`ifdef AES_KEY_STORE_EN
    check("key_ready cleared", 128'(bus.key_ready), 128'd0);
`endif
    wait_rk(3);
    bus.start = 1'b1; bus.key_in = ~K1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_rk(7);
    bus.start = 1'b1; bus.key_in = 128'h0123456789abcdef0123456789abcdef;
    @(negedge clk);
    bus.start = 1'b0;
    wait_rk(10);
    check("ignored rk10", bus.rk_out, K1_R10);
    repeat (2) @(negedge clk);

    // Zero key.
    pulse_start(128'd0);
    wait_rk(1);
    check("zero rk1", bus.rk_out, Z_RK1);
    wait_rk(10);
    check("zero rk10", bus.rk_out, Z_R10);
    repeat (3) @(negedge clk);

    // start held high across two keys: second rk0 right after done.
    k3 = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    bus.start = 1'b1; bus.key_in = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    bus.key_in = k3;
    repeat (11) @(negedge clk);
    bus.start = 1'b0;
    check("b2b rk_idx", 128'(bus.rk_idx), 128'd0);
    check("b2b rk_out", bus.rk_out, k3);
    wait_rk(10);
    repeat (2) @(negedge clk);

    // Reset in the middle of a run.
    pulse_start({$urandom, $urandom, $urandom, $urandom});
    wait_rk(5);
    #2 rst = 1'b1;
    #1;
    check("mid rst rk_valid", 128'(bus.rk_valid), 128'd0);
    check("mid rst busy",     128'(bus.busy),     128'd0);
    check("mid rst done",     128'(bus.done),     128'd0);
    check("mid rst rk_idx",   128'(bus.rk_idx),   128'd0);
    check("mid rst rk_out",   bus.rk_out,         128'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    pulse_start(K1);
    wait_rk(10);
    check("post rst rk10", bus.rk_out, K1_R10);
    repeat (2) @(negedge clk);

    // Random start/key traffic, including back-to-back and ignored starts.
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      bus.start  = ($urandom_range(0, 3) == 0);
      bus.key_in = {$urandom, $urandom, $urandom, $urandom};
    end
    bus.start = 1'b0;
    repeat (15) @(negedge clk);
    check("queue drained", 128'(q.size()), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
